// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg
// Shared types and default sizing for the serial pattern transmitter.
//   seq_tx_state_t      : FSM state encoding (2 bits)
//   SEQ_TX_PAT_W_DEF    : default pattern length in symbols
//   SEQ_TX_DIV_W_DEF    : default width of the bit-period field
package seq_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } seq_tx_state_t;

   localparam int SEQ_TX_PAT_W_DEF = 4;
   localparam int SEQ_TX_DIV_W_DEF = 8;

endpackage

// File: rtl/seq_bit_timer.sv
// seq_bit_timer
// Loadable down-counter that times the hold of one symbol. Loading value P
// makes tc go high P+1 clocks later (P clocks of countdown plus the cycle
// spent at zero). The counter parks at zero rather than wrapping.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : DIV_W-bit reload value
//   tc        : terminal count, high while the counter is zero
module seq_bit_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             tc
);

   logic [DIV_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - DIV_W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// Serial pattern transmitter for the two-button sequence interface. Sends a
// PAT_W-bit code MSB-first as one-hot symbols: p1 for a 1, p2 for a 0. Each
// symbol is held for bit_period+1 clocks with no gap between symbols.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high
//   start       : transmission request, sampled only in IDLE
//   pattern     : code to send, MSB first, latched on accept
//   bit_period  : extra hold clocks per symbol, latched on accept
//   repeat_en   : (SEQ_TX_REPEAT_EN only) restart the pattern seamlessly
//                 when high at the end of the last symbol
//   p1, p2      : registered symbol lines, never both high
//   busy        : high while a symbol is on the lines
//   done        : one-cycle pulse after the last symbol
// Build option: define SEQ_TX_REPEAT_EN to add repeat_en and the reload path.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | lines low, waiting for start
// ST_SEND  | driving the current symbol, hold timer running
// ST_DONE  | lines low, done pulsed for one cycle
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int PAT_W = SEQ_TX_PAT_W_DEF,
   parameter int DIV_W = SEQ_TX_DIV_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [DIV_W-1:0] bit_period,
`ifdef SEQ_TX_REPEAT_EN
   input  logic             repeat_en,
`endif
   output logic             p1,
   output logic             p2,
   output logic             busy,
   output logic             done
);

   localparam int                IDX_W    = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

   seq_tx_state_t    state;
   logic [PAT_W-1:0] shift_q;
   logic [PAT_W-1:0] shift_nxt;
   logic [DIV_W-1:0] period_q;
   logic [IDX_W-1:0] idx_q;
   logic             last_sym;
   logic             wrap;
   logic             tmr_load;
   logic [DIV_W-1:0] tmr_val;
   logic             tmr_tc;
`ifdef SEQ_TX_REPEAT_EN
   logic [PAT_W-1:0] pattern_q;
`endif

   seq_bit_timer #(
      .DIV_W(DIV_W)
   ) u_bit_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   assign shift_nxt = shift_q << 1;
   assign last_sym  = (idx_q == IDX_LAST);

`ifdef SEQ_TX_REPEAT_EN
   assign wrap = repeat_en;
`else
   assign wrap = 1'b0;
`endif

   // Timer is reloaded on accept (from the live input, since the latch
   // happens on the same edge) and at every symbol boundary that is
   // followed by another symbol.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = period_q;
      case (state)
         ST_IDLE: begin
            if (start) begin
               tmr_load = 1'b1;
               tmr_val  = bit_period;
            end
         end
         ST_SEND: begin
            if (tmr_tc && (!last_sym || wrap)) begin
               tmr_load = 1'b1;
            end
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         shift_q   <= '0;
         period_q  <= '0;
         idx_q     <= '0;
         p1        <= 1'b0;
         p2        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef SEQ_TX_REPEAT_EN
         pattern_q <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               p1   <= 1'b0;
               p2   <= 1'b0;
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  shift_q   <= pattern;
                  period_q  <= bit_period;
                  idx_q     <= '0;
`ifdef SEQ_TX_REPEAT_EN
                  pattern_q <= pattern;
`endif
                  p1        <= pattern[PAT_W-1];
                  p2        <= ~pattern[PAT_W-1];
                  busy      <= 1'b1;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tmr_tc) begin
                  if (!last_sym) begin
                     shift_q <= shift_nxt;
                     idx_q   <= idx_q + IDX_W'(1);
                     p1      <= shift_nxt[PAT_W-1];
                     p2      <= ~shift_nxt[PAT_W-1];
`ifdef SEQ_TX_REPEAT_EN
                  end else if (wrap) begin
                     shift_q <= pattern_q;
                     idx_q   <= '0;
                     p1      <= pattern_q[PAT_W-1];
                     p2      <= ~pattern_q[PAT_W-1];
`endif
                  end else begin
                     p1    <= 1'b0;
                     p2    <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               p1    <= 1'b0;
               p2    <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx
// Self-checking bench for seq_pattern_tx (PAT_W = 4, DIV_W = 8). Outputs are
// sampled on the falling edge as the packed vector {p1, p2, busy, done}.
// Repeat-mode sequence is compiled in only when SEQ_TX_REPEAT_EN is defined.
module tb_seq_pattern_tx;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] pattern;
   logic [7:0] bit_period;
`ifdef SEQ_TX_REPEAT_EN
   logic       repeat_en;
`endif
   logic       p1;
   logic       p2;
   logic       busy;
   logic       done;

   int n_checks;
   int n_errors;

   seq_pattern_tx #(
      .PAT_W(4),
      .DIV_W(8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pattern    (pattern),
      .bit_period (bit_period),
`ifdef SEQ_TX_REPEAT_EN
      .repeat_en  (repeat_en),
`endif
      .p1         (p1),
      .p2         (p2),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] pat;
      logic [7:0] per;
      int         exp_done;
   } vec_t;

   vec_t vecs[6];

   // Expected {p1,p2,busy,done} in cycle c after a start accepted at edge 0.
   function automatic logic [3:0] exp_vec(input logic [3:0] pat, input int per, input int c);
      int   len;
      int   k;
      logic b;
      len = 4 * (per + 1);
      if (c >= 1 && c <= len) begin
         k = (c - 1) / (per + 1);
         b = pat[3-k];
         return {b, ~b, 1'b1, 1'b0};
      end else if (c == len + 1) begin
         return 4'b0001;
      end
      return 4'b0000;
   endfunction

   task automatic chk(input string name, input int cyc, input logic [3:0] exp);
      logic [3:0] act;
      act = {p1, p2, busy, done};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: {p1,p2,busy,done} got %b required %b", name, cyc, act, exp);
      end
   endtask

   initial begin
      int done_seen;
      int len;

      vecs[0] = '{pat: 4'b1100, per: 8'd0,   exp_done: 5};
      vecs[1] = '{pat: 4'b1010, per: 8'd2,   exp_done: 13};
      vecs[2] = '{pat: 4'b0001, per: 8'hFF,  exp_done: 1025};
      vecs[3] = '{pat: 4'b0110, per: 8'd1,   exp_done: 9};
      vecs[4] = '{pat: 4'b1111, per: 8'd0,   exp_done: 5};
      vecs[5] = '{pat: 4'b0000, per: 8'd3,   exp_done: 17};

      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b1;
      start      = 1'b0;
      pattern    = 4'b0000;
      bit_period = 8'd0;
`ifdef SEQ_TX_REPEAT_EN
      repeat_en  = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_state", 0, 4'b0000);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_release", 0, 4'b0000);

      // Table-driven single transmissions
      foreach (vecs[i]) begin
         @(negedge clk);
         start      = 1'b1;
         pattern    = vecs[i].pat;
         bit_period = vecs[i].per;
         @(posedge clk);
         @(negedge clk);
         start      = 1'b0;
         pattern    = ~vecs[i].pat;
         bit_period = 8'd0;
         done_seen  = -1;
         len        = 4 * (int'(vecs[i].per) + 1);
         for (int c = 1; c <= len + 2; c++) begin
            chk($sformatf("vec%0d", i), c, exp_vec(vecs[i].pat, int'(vecs[i].per), c));
            if (done === 1'b1 && done_seen < 0) done_seen = c;
            if (c < len + 2) @(negedge clk);
         end
         n_checks++;
         if (done_seen != vecs[i].exp_done) begin
            n_errors++;
            $display("FAIL vec%0d_done_cycle: got %0d required %0d", i, done_seen, vecs[i].exp_done);
         end
      end

      // start held high, pattern changed mid-flight; second run only after done
      @(negedge clk);
      start      = 1'b1;
      pattern    = 4'b1100;
      bit_period = 8'd0;
      @(posedge clk);
      @(negedge clk);
      for (int c = 1; c <= 12; c++) begin
         if (c == 2) pattern = 4'b0000;
         if (c == 7) start = 1'b0;
         if (c <= 5)       chk("hold_start", c, exp_vec(4'b1100, 0, c));
         else if (c == 6)  chk("hold_start_gap", c, 4'b0000);
         else              chk("hold_start_2nd", c, exp_vec(4'b0000, 0, c - 6));
         if (c < 12) @(negedge clk);
      end

      // reset during SEND aborts with no done pulse
      @(negedge clk);
      start      = 1'b1;
      pattern    = 4'b1100;
      bit_period = 8'd0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("abort_c1", 1, 4'b1010);
      @(negedge clk);
      chk("abort_c2", 2, 4'b1010);
      @(negedge clk);
      chk("abort_c3_pre", 3, 4'b0110);
      reset = 1'b1;
      #1;
      chk("abort_immediate", 3, 4'b0000);
      @(negedge clk);
      chk("abort_held", 4, 4'b0000);
      reset = 1'b0;
      for (int c = 5; c <= 10; c++) begin
         @(negedge clk);
         chk("abort_idle", c, 4'b0000);
      end

`ifdef SEQ_TX_REPEAT_EN
      // repeat: 1100 1100 continuous, drop repeat during second pass
      @(negedge clk);
      start      = 1'b1;
      repeat_en  = 1'b1;
      pattern    = 4'b1100;
      bit_period = 8'd0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (c == 6) repeat_en = 1'b0;
         if (c <= 8)      chk("repeat_stream", c, exp_vec(4'b1100, 0, ((c - 1) % 4) + 1));
         else if (c == 9) chk("repeat_done", c, 4'b0001);
         else             chk("repeat_idle", c, 4'b0000);
         if (c < 10) @(negedge clk);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // One-hot guard: both symbol lines high is never legal
   always @(negedge clk) begin
      if (p1 === 1'b1 && p2 === 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL onehot: p1=%b p2=%b required not both 1", p1, p2);
      end
   end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter for the two-button sequence interface. It drives a PAT_W-bit code MSB-first onto the one-hot symbol lines p1 (bit = 1) and p2 (bit = 0), holding each symbol for a programmable number of clocks. It is the transmit end of the Lab 7 sequence-detector link: it generates the 1/0 stimulus that the Moore detector consumes, in place of the physical buttons on the board and in benches.

## Interface
- PAT_W, 4, pattern length in symbols (≥ 2)
- DIV_W, 8, width of the bit-period field
- clk  input  1  system clock, rising edge
- reset  input  1  reset, asynchronous, active-high; clock clk
- start  input  1  request a transmission; sampled only in IDLE
- pattern  input  PAT_W  code to send; bit PAT_W-1 is sent first; latched on accept
- bit_period  input  DIV_W  extra hold clocks per symbol; each symbol lasts bit_period+1 clocks; latched on accept
- p1  output  1  symbol "1" line, registered
- p2  output  1  symbol "0" line, registered
- busy  output  1  high while symbols are on the lines
- done  output  1  single-cycle pulse after the last symbol

## Operation
- States: IDLE, SEND, DONE.
- IDLE: p1 = p2 = 0, busy = 0, done = 0. When start = 1, latch pattern into the shift register, latch bit_period, clear the symbol counter and go to SEND.
- SEND: p1 = current bit, p2 = ~current bit; exactly one line is high. The hold counter counts 0..bit_period. At terminal count: if the symbol index is PAT_W-1, go to DONE; otherwise shift left one bit, increment the index and reload the hold counter. There is no gap between consecutive symbols.
- DONE: p1 = p2 = 0, busy = 0, done = 1 for one cycle, then IDLE unconditionally.
- start is ignored in SEND and DONE; no queuing.
- pattern and bit_period changes after accept have no effect on the current transmission.
- bit_period = 0 means one clock per symbol. The maximum is 2^DIV_W − 1, giving 2^DIV_W clocks per symbol. Counters are DIV_W bits wide and never wrap mid-symbol.
- Reset values (asynchronous, any state): state IDLE, p1 = 0, p2 = 0, busy = 0, done = 0, counters 0. Reset during SEND aborts immediately with no done pulse.
- p1 and p2 must never both be high in any cycle, including the reset-release cycle.

## Timing
- start sampled high at edge 0 in IDLE, so the first symbol appears on p1/p2 after edge 0 (cycle 1). Latency: 1 clock.
- Symbol k (k = 0..PAT_W-1) occupies cycles 1 + k·(P+1) through (k+1)·(P+1), where P = bit_period.
- done is high in cycle PAT_W·(P+1) + 1. busy covers exactly the SEND cycles.
- The earliest next accepted start is sampled in the cycle after done, so there are at least 2 idle clocks between transmissions.
- All outputs come directly from flops, with no combinational path from the inputs.

## Configuration
- SEQ_TX_REPEAT_EN defined: adds input port repeat (1 bit). If repeat = 1 at the terminal count of the last symbol, the latched pattern is reloaded and symbol 0 follows with no gap. busy stays high and done is not pulsed. If repeat = 0, the block goes to DONE as normal.
- SEQ_TX_REPEAT_EN undefined: the repeat port and reload logic are absent, and every transmission is one-shot.

## Structure
- Package seq_tx_pkg: state typedef (IDLE, SEND, DONE) with 2-bit encoding, and default constants for PAT_W and DIV_W.
- Sub-module seq_bit_timer: loadable DIV_W down-counter with terminal-count tick, used for per-symbol hold. The shift register, symbol index and FSM stay in the top level.

## Test plan
- pattern = 4'b1100, bit_period = 0, start pulse: p1 high in cycles 1–2, p2 high in cycles 3–4, done in cycle 5. Outputs fed to the detector give z = 1 one cycle after the last symbol.
- pattern = 4'b1010, bit_period = 2: each symbol is 3 clocks; p1 in cycles 1–3 and 7–9, p2 in cycles 4–6 and 10–12; done in cycle 13; busy high for cycles 1–12.
- start held high through a transmission, with pattern changed to 4'b0000 at cycle 2: the 1100 sequence is unaffected. A second transmission (of 0000, p2 for 4 cycles) is accepted only in the cycle after done.
- reset asserted in cycle 3 of a bit_period = 0 transmission: p1 = p2 = busy = done = 0 immediately, with no done pulse. After release the block is idle until the next start.
- bit_period = 8'hFF, pattern = 4'b0001: each symbol lasts 256 clocks, p1 rises only at cycle 769, and done is at cycle 1025.
- SEQ_TX_REPEAT_EN, repeat = 1, pattern = 4'b1100: the sequence 1,1,0,0,1,1,0,0 is continuous with no done. Dropping repeat during the second pass gives done right after that pass.
